stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl_if.sv | 21 ++
 rtl/stopwatch_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Button and status bundle between the stopwatch front panel and its controller.
// The master side owns the raw buttons; the slave side (the controller) drives the status outputs.
interface stopwatch_ctrl_if;
  logic start_btn;
  logic clr_btn;
  logic lap_btn;
  logic sec_tick;
  logic clr;
  logic run;
  logic lap_hold;

  modport master (
    output start_btn, clr_btn, lap_btn,
    input  sec_tick, clr, run, lap_hold
  );

  modport slave (
    input  start_btn, clr_btn, lap_btn,
    output sec_tick, clr, run, lap_hold
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/clear/lap buttons, IDLE/RUN/PAUSE FSM and seconds prescaler.
// Define STOPWATCH_LAP_EN to build the lap debouncer and the lap_hold freeze logic.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 100000000,
  parameter int DEB_CYCLES = 1000000
) (
  input logic        clk,
  input logic        reset,
  stopwatch_ctrl_if.slave sw
);

`ifdef STOPWATCH_LAP_EN
  localparam int NBTN = 3;
`else
  localparam int NBTN = 2;
`endif
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [26:0] TC = 27'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] sync1;
  logic [NBTN-1:0] sync2;
  logic [NBTN-1:0] acc;
  logic [NBTN-1:0] acc_d;
  logic [NBTN-1:0] press;
  logic [DW-1:0]   deb_cnt [NBTN];

  state_t      state;
  state_t      state_nxt;
  logic [26:0] presc;
  logic [26:0] presc_nxt;
  logic        start_p;
  logic        clr_p;
  logic        clr_nxt;
  logic        run_q;
  logic        clr_q;
  logic        tick_q;

`ifdef STOPWATCH_LAP_EN
  logic        lap_p;
  logic        lap_nxt;
  logic        lap_q;
  assign raw   = {sw.lap_btn, sw.clr_btn, sw.start_btn};
  assign lap_p = press[2];
`else
  assign raw   = {sw.clr_btn, sw.start_btn};
`endif

  assign start_p = press[0];
  assign clr_p   = press[1];

  // Accepted level only follows the synchronised level after it has differed for DEB_CYCLES
  // consecutive cycles; the press pulse is the registered rising edge of the accepted level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      acc   <= '0;
      acc_d <= '0;
      press <= '0;
      for (int i = 0; i < NBTN; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      acc_d <= acc;
      press <= acc & ~acc_d;
      for (int i = 0; i < NBTN; i++) begin
        if (sync2[i] == acc[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          acc[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Clear beats start outside RUN; inside RUN start beats clear, which is otherwise ignored.
  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    presc_nxt = presc;
    case (state)
      IDLE: begin
        if (clr_p) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
        end else if (start_p) begin
          state_nxt = RUN;
        end
        presc_nxt = '0;
      end
      RUN: begin
        if (start_p) state_nxt = PAUSE;
        presc_nxt = (presc == TC) ? 27'd0 : presc + 27'd1;
      end
      PAUSE: begin
        if (clr_p) begin
          state_nxt = IDLE;
          clr_nxt   = 1'b1;
          presc_nxt = '0;
        end else if (start_p) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = IDLE;
        presc_nxt = '0;
      end
    endcase
  end

`ifdef STOPWATCH_LAP_EN
  always_comb begin
    lap_nxt = lap_q;
    if (state_nxt == IDLE) begin
      lap_nxt = 1'b0;
    end else if (lap_p) begin
      lap_nxt = (state == RUN) ? ~lap_q : 1'b0;
    end
  end
`endif

  // Outputs are registered from next-state values, so sec_tick is high exactly in the cycle
  // the prescaler holds its terminal count while RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      presc  <= '0;
      run_q  <= 1'b0;
      clr_q  <= 1'b0;
      tick_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_q  <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      presc  <= presc_nxt;
      run_q  <= (state_nxt == RUN);
      clr_q  <= clr_nxt;
      tick_q <= (state_nxt == RUN) && (presc_nxt == TC);
`ifdef STOPWATCH_LAP_EN
      lap_q  <= lap_nxt;
`endif
    end
  end

  assign sw.sec_tick = tick_q;
  assign sw.clr      = clr_q;
  assign sw.run      = run_q;
`ifdef STOPWATCH_LAP_EN
  assign sw.lap_hold = lap_q;
`else
  assign sw.lap_hold = 1'b0;
`endif

endmodule
